// File: rtl/clk_rst_pkg.sv
// Shared encodings for the CPU clock-enable / reset controller.
// The FSM state values are visible on the debug LED port, so they are fixed here.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

endpackage

// File: rtl/clk_prescaler.sv
// Free-running prescaler producing a one-cycle tick every 2^(k+1) clki cycles
// and the legacy square-wave cpu_clk, with k taken from a registered div_sel.
module clk_prescaler #(
    parameter int DIV_W = 32,
    parameter int SEL_W = 5
) (
    input  logic             clki,
    input  logic             rst,
    input  logic [SEL_W-1:0] div_sel,
    output logic             tick,
    output logic             cpu_clk
);

    localparam int K_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] lo_mask;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_qq;
    logic [K_W-1:0]   k;
    logic             sel_chg;

    always_comb begin
        if (32'(sel_q) >= DIV_W) begin
            k = K_W'(DIV_W - 1);
        end else begin
            k = K_W'(sel_q);
        end
    end

    // sel_q already carries the new rate while cnt still holds the old phase;
    // that one cycle must not decode a tick, and cnt restarts from zero next.
    assign sel_chg = (sel_q != sel_qq);
    assign lo_mask = (DIV_W'(1) << k) - DIV_W'(1);
    assign tick    = !sel_chg && !cnt[k] && ((cnt & lo_mask) == lo_mask);
    assign cnt_nxt = sel_chg ? '0 : cnt + DIV_W'(1);

    always_ff @(posedge clki) begin
        if (rst) begin
            cnt     <= '0;
            sel_q   <= div_sel;
            sel_qq  <= div_sel;
            cpu_clk <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            sel_q   <= div_sel;
            sel_qq  <= sel_q;
            cpu_clk <= cnt_nxt[k];
        end
    end

endmodule

// File: rtl/clk_rst_ctrl.sv
// CPU clock-enable and reset sequencer: stretched reset, run/halt/single-step
// control on top of clk_prescaler, plus a debug count of delivered enables.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RESET | cpu_rst high, enables still pulse, hold counts down per tick
// ST_RUN   | cpu_ce on every tick
// ST_HALT  | no enables; waits for run mode or a step edge in step mode
// ST_STEP  | one enable on the next tick, then back to halt
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int DIV_W    = 32,
    parameter int SEL_W    = 5,
    parameter int RST_HOLD = 3,
    parameter int CNT_W    = 32
) (
    input  logic             clki,
    input  logic             rst,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic             ext_rst_req,
    output logic             cpu_ce,
    output logic             cpu_clk,
    output logic             cpu_rst,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count
);

    localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

    state_t            state_q;
    logic [HOLD_W-1:0] hold;
    logic              step_prev;
    logic              step_edge;
    logic              tick;

    clk_prescaler #(
        .DIV_W (DIV_W),
        .SEL_W (SEL_W)
    ) u_prescaler (
        .clki    (clki),
        .rst     (rst),
        .div_sel (div_sel),
        .tick    (tick),
        .cpu_clk (cpu_clk)
    );

    assign step_edge = step_req & ~step_prev;
    assign state     = state_q;

    always_ff @(posedge clki) begin
        if (rst) begin
            state_q    <= ST_RESET;
            hold       <= HOLD_INIT;
            cpu_rst    <= 1'b1;
            cpu_ce     <= 1'b0;
            tick_count <= '0;
            step_prev  <= 1'b0;
        end else begin
            step_prev <= step_req;
            cpu_ce    <= 1'b0;
            if (cpu_ce && !cpu_rst) begin
                tick_count <= tick_count + CNT_W'(1);
            end

            if (ext_rst_req) begin
                state_q    <= ST_RESET;
                hold       <= HOLD_INIT;
                cpu_rst    <= 1'b1;
                tick_count <= '0;
            end else begin
                case (state_q)
                    ST_RESET: begin
                        // hold hits zero the cycle the last reset enable is
                        // out, so that enable still sees cpu_rst high.
                        if (hold == '0) begin
                            state_q <= (mode == MODE_RUN) ? ST_RUN : ST_HALT;
                            cpu_rst <= 1'b0;
                        end else begin
                            cpu_ce <= tick;
                            if (tick) begin
                                hold <= hold - HOLD_W'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (mode != MODE_RUN) begin
                            state_q <= ST_HALT;
                        end else begin
                            cpu_ce <= tick;
                        end
                    end
                    ST_HALT: begin
                        if (mode == MODE_RUN) begin
                            state_q <= ST_RUN;
                        end else if (step_edge && (mode == MODE_STEP)) begin
                            state_q <= ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        if (mode != MODE_STEP) begin
                            state_q <= ST_HALT;
                        end else if (tick) begin
                            cpu_ce  <= 1'b1;
                            state_q <= ST_HALT;
                        end
                    end
                    default: state_q <= ST_RESET;
                endcase
            end
        end
    end

endmodule
